ifu_fetch: RTL

- Instruction fetch stage of the single-issue NPC core; sits directly upstream of the decoder.
- Owns the PC and issues one fetch at a time to instruction memory over a request/response handshake.
- Holds the returned instruction and its PC in a one-entry output buffer, presented to the decoder with a valid/ready handshake.
- Accepts control-flow redirects from execute and a sticky halt (ebreak) from the decode/trap path.

---
 rtl/npc_pkg.sv | 15 +
 rtl/ifu_fetch_if.sv | 30 +++
 rtl/ifu_pc_reg.sv | 37 +++
 rtl/ifu_fetch.sv | 85 ++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared NPC core types and constants: datapath width, reset PC, NOP encoding, fetch FSM states.
package npc_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NPC_RESET_PC = 32'h8000_0000;
    localparam logic [XLEN-1:0] NOP_INSN     = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bundle: redirect/halt control, imem request/response, decoder handshake.
interface ifu_fetch_if;
  import npc_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            halted;

  modport master (
    input  redirect_valid, redirect_pc, halt,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, halted
  );

  modport slave (
    output redirect_valid, redirect_pc, halt,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, halted
  );
endinterface

// File: rtl/ifu_pc_reg.sv
// PC register with next-PC mux: redirect (word aligned) beats +4, otherwise hold.
// Updates on the clock edge; no handshake of its own.
module ifu_pc_reg
  import npc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = NPC_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            incr_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i & ~XLEN'(3);
    end else if (incr_i) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// Non-pipelined fetch: one imem request in flight, result held in a one-entry buffer for decode.
// Min 3 cycles/instruction; decoder backpressure holds the buffer and blocks the next request.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = NPC_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  ifu_fetch_if.master bus
);

  fetch_state_e    state_q;
  logic            kill_q;
  logic            halted_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic [XLEN-1:0] pc;
  logic            redirect;
  logic            req_fire;
  logic            rsp_keep;

  assign redirect = bus.redirect_valid;
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  // Response is kept only if no redirect landed since (kill_q) or in this cycle.
  assign rsp_keep = (state_q == S_WAIT) && bus.imem_rsp_valid && !kill_q && !redirect;

  ifu_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect),
    .redirect_pc_i (bus.redirect_pc),
    .incr_i        (rsp_keep),
    .pc_o          (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      kill_q    <= 1'b0;
      halted_q  <= 1'b0;
      inst_q    <= NOP_INSN;
      inst_pc_q <= '0;
    end else begin
      if (bus.halt) begin
        halted_q <= 1'b1;
      end
      unique case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (req_fire) begin
            state_q <= S_WAIT;
            kill_q  <= redirect;
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            kill_q  <= 1'b0;
            state_q <= rsp_keep ? S_HOLD : S_REQ;
            if (rsp_keep) begin
              inst_q    <= bus.imem_rsp_data;
              inst_pc_q <= pc;
            end
          end else if (redirect) begin
            kill_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect || bus.inst_ready) begin
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_req_valid = (state_q == S_REQ) && !halted_q;
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = (state_q == S_HOLD) && !redirect;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.halted         = halted_q;

endmodule
